// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one 16-bit Hack ALU between two requesters (A and B) using
//   valid/ready handshakes. A round-robin arbiter grants one requester at a
//   time, its operands are latched, the ALU is evaluated on the latched
//   operands for one cycle, and the result is held on the response port until
//   the consumer takes it.
//
//   Optional feature macro: ALU_ARB_FLAGS_EN
//     defined   -> rsp_zr_o / rsp_ng_o ports and their flag registers exist
//     undefined -> flag ports and registers are removed; nothing else changes
//
// Parameters
//   DATA_W     operand/result width (only 16 is meaningful for the Hack ALU)
//   START_PRI  requester holding priority after reset (0 = A, 1 = B)
//
// Ports
//   clk_i        in   clock, rising edge
//   rst_i        in   synchronous reset, active high
//   a_valid_i    in   requester A has an op
//   a_ready_o    out  A op accepted this cycle (combinational)
//   a_x_i/a_y_i  in   A operands
//   a_ctrl_i     in   A control {zx,nx,zy,ny,f,no}
//   b_*          same as A, for requester B
//   rsp_valid_o  out  result valid
//   rsp_ready_i  in   consumer takes result
//   rsp_id_o     out  owner of the result (0 = A, 1 = B)
//   rsp_out_o    out  ALU result
//   rsp_zr_o     out  result == 0          (flag build only)
//   rsp_ng_o     out  result sign bit      (flag build only)
//
// FSM states
//   state  | meaning
//   IDLE   | waiting for a valid requester; ready goes to the granted one
//   EXEC   | ALU evaluates latched operands; result captured at end of cycle
//   RESP   | result presented until rsp_valid_o & rsp_ready_i
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int DATA_W    = 16,
  parameter bit START_PRI = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [DATA_W-1:0] a_x_i,
  input  logic [DATA_W-1:0] a_y_i,
  input  logic [5:0]        a_ctrl_i,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic [DATA_W-1:0] b_x_i,
  input  logic [DATA_W-1:0] b_y_i,
  input  logic [5:0]        b_ctrl_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_id_o,
  output logic [DATA_W-1:0] rsp_out_o
`ifdef ALU_ARB_FLAGS_EN
  ,
  output logic              rsp_zr_o,
  output logic              rsp_ng_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  // pri_q: requester that wins when both are valid
  logic              pri_q;
  logic              grant_a, grant_b;
  logic              rsp_fire;

  // Latched request (owned by EXEC)
  logic [DATA_W-1:0] x_q, y_q;
  logic [5:0]        ctrl_q;
  logic              id_q;

  // Held response (owned by RESP)
  logic [DATA_W-1:0] out_q;
  logic              rsp_id_q;
  logic [DATA_W-1:0] alu_res;

  // ---------------------------------------------------------------------------
  // Hack ALU: zx/nx pre-process x, zy/ny pre-process y, f selects add or and,
  // no inverts the result. Addition wraps modulo 2^DATA_W.
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] hack_alu(
    input logic [DATA_W-1:0] x,
    input logic [DATA_W-1:0] y,
    input logic [5:0]        ctrl
  );
    logic [DATA_W-1:0] xa, ya, r;
    xa = ctrl[5] ? '0 : x;
    xa = ctrl[4] ? ~xa : xa;
    ya = ctrl[3] ? '0 : y;
    ya = ctrl[2] ? ~ya : ya;
    r  = ctrl[1] ? (xa + ya) : (xa & ya);
    r  = ctrl[0] ? ~r : r;
    return r;
  endfunction

  assign alu_res = hack_alu(x_q, y_q, ctrl_q);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_fire    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A lone valid requester always wins; on contention pri_q decides.
        grant_a = a_valid_i & (~b_valid_i | ~pri_q);
        grant_b = b_valid_i & (~a_valid_i |  pri_q);
        if (grant_a | grant_b) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        rsp_fire    = rsp_ready_i;
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign a_ready_o = grant_a;
  assign b_ready_o = grant_b;

  // ---------------------------------------------------------------------------
  // Request latch, priority pointer, and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pri_q    <= START_PRI;
      x_q      <= '0;
      y_q      <= '0;
      ctrl_q   <= '0;
      id_q     <= 1'b0;
      out_q    <= '0;
      rsp_id_q <= 1'b0;
    end else begin
      if (grant_a) begin
        x_q    <= a_x_i;
        y_q    <= a_y_i;
        ctrl_q <= a_ctrl_i;
        id_q   <= 1'b0;
      end else if (grant_b) begin
        x_q    <= b_x_i;
        y_q    <= b_y_i;
        ctrl_q <= b_ctrl_i;
        id_q   <= 1'b1;
      end

      // Response id is captured together with the result so rsp_id_o never
      // moves while a new request is being latched.
      if (state_q == S_EXEC) begin
        out_q    <= alu_res;
        rsp_id_q <= id_q;
      end

      // The requester just served drops to lowest priority.
      if (rsp_fire) begin
        pri_q <= ~rsp_id_q;
      end
    end
  end

  assign rsp_id_o  = rsp_id_q;
  assign rsp_out_o = out_q;

`ifdef ALU_ARB_FLAGS_EN
  logic zr_q, ng_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      zr_q <= 1'b0;
      ng_q <= 1'b0;
    end else if (state_q == S_EXEC) begin
      zr_q <= (alu_res == '0);
      ng_q <= alu_res[DATA_W-1];
    end
  end

  assign rsp_zr_o = zr_q;
  assign rsp_ng_o = ng_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk;
  logic        rst_i;
  logic        a_valid_i, b_valid_i;
  logic        a_ready_o, b_ready_o;
  logic [15:0] a_x_i, a_y_i, b_x_i, b_y_i;
  logic [5:0]  a_ctrl_i, b_ctrl_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_id_o;
  logic [15:0] rsp_out_o;
`ifdef ALU_ARB_FLAGS_EN
  logic        rsp_zr_o, rsp_ng_o;
`endif

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.DATA_W(16), .START_PRI(1'b0)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .a_valid_i   (a_valid_i),
    .a_ready_o   (a_ready_o),
    .a_x_i       (a_x_i),
    .a_y_i       (a_y_i),
    .a_ctrl_i    (a_ctrl_i),
    .b_valid_i   (b_valid_i),
    .b_ready_o   (b_ready_o),
    .b_x_i       (b_x_i),
    .b_y_i       (b_y_i),
    .b_ctrl_i    (b_ctrl_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_o    (rsp_id_o),
    .rsp_out_o   (rsp_out_o)
`ifdef ALU_ARB_FLAGS_EN
    ,
    .rsp_zr_o    (rsp_zr_o),
    .rsp_ng_o    (rsp_ng_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the Hack definition.
  function automatic logic [15:0] hack(input logic [15:0] x, input logic [15:0] y,
                                       input logic [5:0] c);
    logic [15:0] xx, yy, r;
    xx = c[5] ? 16'h0000 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0000 : y;
    if (c[2]) yy = ~yy;
    r = c[1] ? 16'(xx + yy) : (xx & yy);
    if (c[0]) r = ~r;
    return r;
  endfunction

  // Transaction-level model: one op in flight, result visible one cycle
  // after the accepting edge's following cycle, round-robin pointer.
  bit          m_busy = 0;
  int          m_age  = 0;
  bit          m_pri  = 0;
  logic [15:0] m_out  = 16'h0;
  bit          m_id   = 0;
  bit          served[$];

  always @(negedge clk) begin
    bit exp_ga, exp_gb, exp_v;
    if (rst_i) begin
      m_busy = 0;
      m_age  = 0;
      m_pri  = 0;
    end else begin
      exp_ga = !m_busy && a_valid_i && (!b_valid_i || !m_pri);
      exp_gb = !m_busy && b_valid_i && (!a_valid_i ||  m_pri);
      exp_v  = m_busy && (m_age >= 1);
      chk("a_ready", 32'(a_ready_o), 32'(exp_ga));
      chk("b_ready", 32'(b_ready_o), 32'(exp_gb));
      chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_v));
      if (exp_v) begin
        chk("rsp_out", 32'(rsp_out_o), 32'(m_out));
        chk("rsp_id", 32'(rsp_id_o), 32'(m_id));
`ifdef ALU_ARB_FLAGS_EN
        chk("rsp_zr", 32'(rsp_zr_o), 32'(m_out == 16'h0));
        chk("rsp_ng", 32'(rsp_ng_o), 32'(m_out[15]));
`endif
      end
      if (a_ready_o) served.push_back(1'b0);
      if (b_ready_o) served.push_back(1'b1);
      if (m_busy) begin
        if (exp_v) begin
          if (rsp_ready_i) begin
            m_busy = 0;
            m_pri  = ~m_id;
          end
        end else begin
          m_age++;
        end
      end else if (exp_ga) begin
        m_busy = 1; m_age = 0; m_id = 0;
        m_out  = hack(a_x_i, a_y_i, a_ctrl_i);
      end else if (exp_gb) begin
        m_busy = 1; m_age = 0; m_id = 1;
        m_out  = hack(b_x_i, b_y_i, b_ctrl_i);
      end
    end
  end

  task automatic req_a(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
    bit got = 0;
    a_x_i = x; a_y_i = y; a_ctrl_i = c; a_valid_i = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (a_ready_o) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL a_accept_timeout actual=no_ready required=ready");
    end
    @(posedge clk); #1;
    a_valid_i = 1'b0;
  endtask

  task automatic req_b(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
    bit got = 0;
    b_x_i = x; b_y_i = y; b_ctrl_i = c; b_valid_i = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (b_ready_o) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL b_accept_timeout actual=no_ready required=ready");
    end
    @(posedge clk); #1;
    b_valid_i = 1'b0;
  endtask

  // Returns at the negedge where rsp_valid_o is first seen; n = negedges waited.
  task automatic wait_rsp(output int n);
    bit got = 0;
    n = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      n++;
      if (rsp_valid_o) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL rsp_timeout actual=no_valid required=valid");
    end
  endtask

  task automatic wait_served(input int target);
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (served.size() >= target) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL served_timeout actual=%0d required=%0d", served.size(), target);
    end
  endtask

  initial begin
    int n;
    int base;
    rst_i = 1'b1; rsp_ready_i = 1'b0;
    a_valid_i = 1'b0; a_x_i = '0; a_y_i = '0; a_ctrl_i = '0;
    b_valid_i = 1'b0; b_x_i = '0; b_y_i = '0; b_ctrl_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    chk("reset_rsp_valid", 32'(rsp_valid_o), 32'h0);
    chk("reset_rsp_out", 32'(rsp_out_o), 32'h0);
    chk("reset_rsp_id", 32'(rsp_id_o), 32'h0);
    chk("reset_a_ready", 32'(a_ready_o), 32'h0);
    chk("reset_b_ready", 32'(b_ready_o), 32'h0);

    // A only: 0x11 + 3
    rsp_ready_i = 1'b1;
    req_a(16'h0011, 16'h0003, 6'b000010);
    wait_rsp(n);
    chk("t1_latency", 32'(n), 32'd2);
    chk("t1_out", 32'(rsp_out_o), 32'h0014);
    chk("t1_id", 32'(rsp_id_o), 32'h0);
`ifdef ALU_ARB_FLAGS_EN
    chk("t1_zr", 32'(rsp_zr_o), 32'h0);
    chk("t1_ng", 32'(rsp_ng_o), 32'h0);
`endif
    @(posedge clk); #1;

    // B only: ~(x + ~y)
    req_b(16'h0011, 16'h0003, 6'b000111);
    wait_rsp(n);
    chk("t2_out", 32'(rsp_out_o), 32'hFFF2);
    chk("t2_id", 32'(rsp_id_o), 32'h1);
`ifdef ALU_ARB_FLAGS_EN
    chk("t2_ng", 32'(rsp_ng_o), 32'h1);
    chk("t2_zr", 32'(rsp_zr_o), 32'h0);
`endif
    @(posedge clk); #1;

    // Both held valid: alternation A,B,A,B
    base = served.size();
    a_x_i = 16'h0011; a_y_i = 16'h0003; a_ctrl_i = 6'b010011;
    b_x_i = 16'h0011; b_y_i = 16'h0003; b_ctrl_i = 6'b101010;
    a_valid_i = 1'b1; b_valid_i = 1'b1;
    wait_served(base + 4);
    @(posedge clk); #1;
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    if (served.size() >= base + 4) begin
      chk("t3_order0", 32'(served[base]),     32'h0);
      chk("t3_order1", 32'(served[base + 1]), 32'h1);
      chk("t3_order2", 32'(served[base + 2]), 32'h0);
      chk("t3_order3", 32'(served[base + 3]), 32'h1);
    end
    chk("t3_model_a", 32'(hack(16'h0011, 16'h0003, 6'b010011)), 32'h000E);
    chk("t3_model_b", 32'(hack(16'h0011, 16'h0003, 6'b101010)), 32'h0000);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure with B waiting
    rsp_ready_i = 1'b0;
    req_a(16'h0005, 16'h0007, 6'b000010);
    b_x_i = 16'h0002; b_y_i = 16'h0009; b_ctrl_i = 6'b000010; b_valid_i = 1'b1;
    wait_rsp(n);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("t4_hold_valid", 32'(rsp_valid_o), 32'h1);
      chk("t4_hold_out", 32'(rsp_out_o), 32'h000C);
      chk("t4_hold_id", 32'(rsp_id_o), 32'h0);
      chk("t4_no_b_ready", 32'(b_ready_o), 32'h0);
    end
    @(posedge clk); #1;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_idle_valid", 32'(rsp_valid_o), 32'h0);
    chk("t4_idle_b_ready", 32'(b_ready_o), 32'h1);
    @(posedge clk); #1;
    b_valid_i = 1'b0;
    wait_rsp(n);
    chk("t4_b_out", 32'(rsp_out_o), 32'h000B);
    chk("t4_b_id", 32'(rsp_id_o), 32'h1);
    @(posedge clk); #1;

    // Serve A so B holds priority, then reset an op during EXEC
    req_a(16'h0001, 16'h0001, 6'b000010);
    wait_rsp(n);
    chk("t5_pre_out", 32'(rsp_out_o), 32'h0002);
    @(posedge clk); #1;
    req_a(16'h0100, 16'h0001, 6'b000010);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk("t5_rst_valid", 32'(rsp_valid_o), 32'h0);
    chk("t5_rst_out", 32'(rsp_out_o), 32'h0);
    repeat (3) @(negedge clk);
    chk("t5_no_answer", 32'(rsp_valid_o), 32'h0);
    @(posedge clk); #1;
    base = served.size();
    a_x_i = 16'h0003; a_y_i = 16'h0004; a_ctrl_i = 6'b000010;
    b_x_i = 16'h0003; b_y_i = 16'h0004; b_ctrl_i = 6'b101010;
    a_valid_i = 1'b1; b_valid_i = 1'b1;
    wait_served(base + 1);
    @(posedge clk); #1;
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    if (served.size() >= base + 1) begin
      chk("t5_pri_reset", 32'(served[base]), 32'h0);
    end
    wait_rsp(n);
    chk("t5_out", 32'(rsp_out_o), 32'h0007);
    repeat (4) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
